// File: rtl/rom_stream_reader.sv
// Read-side master for single-port synchronous ROMs: issues active-low reads and
// streams a programmed run of words through a 2-entry valid/ready output buffer.
module rom_stream_reader #(
  parameter int ROM_DEPTH = 1024,
  parameter int NUM_DATA  = 1,
  parameter int BIT_WIDTH = 16,
  localparam int AW = $clog2(ROM_DEPTH),
  localparam int LW = $clog2(ROM_DEPTH + 1),
  localparam int DW = NUM_DATA * BIT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  output logic          rom_cen,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] last_addr;
  logic [LW-1:0] remaining;
  logic [1:0]    occ;
  logic          pend;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          issue;
  logic          pop;
  logic [1:0]    occ_next;

  assign out_valid = (occ != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid & out_ready;

  // A read may only issue if its data is guaranteed a FIFO slot when it returns next cycle.
  always_comb begin
    issue = 1'b0;
    if (state == READ && remaining != '0)
      issue = ({1'b0, occ} + {2'b00, pend} + 3'd1) <= (3'd2 + {2'b00, pop});
  end

  assign rom_cen  = ~issue;
  assign rom_addr = issue ? cur_addr : last_addr;
  assign occ_next = occ + {1'b0, pend} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      last_addr <= '0;
      remaining <= '0;
      occ       <= '0;
      pend      <= 1'b0;
      head      <= '0;
      tail      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= issue;
      occ  <= occ_next;

      // Head register is the FIFO output; tail only holds the second word.
      if (pend && pop) begin
        if (occ == 2'd2) begin
          head <= tail;
          tail <= rom_q;
        end else begin
          head <= rom_q;
        end
      end else if (pend) begin
        if (occ == 2'd0) head <= rom_q;
        else             tail <= rom_q;
      end else if (pop) begin
        head <= tail;
      end

      if (issue) begin
        last_addr <= cur_addr;
        cur_addr  <= (cur_addr == AW'(ROM_DEPTH - 1)) ? '0 : cur_addr + AW'(1);
        remaining <= remaining - LW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= length;
            busy      <= 1'b1;
            state     <= (length == '0) ? DRAIN : READ;
          end
        end
        READ: begin
          if (issue && remaining == LW'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // Finish once nothing is in flight and the last word leaves this cycle.
          if (!pend && occ_next == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
